reg_trace_buffer: RTL and testbench
===================================

# reg_trace_buffer

Downstream observation stage for `single_cycle_computer_all`. It samples the core's `RegisterOut_0` and `FLAG_OUT` every clock, detects changes, and timestamps each change. Each change is pushed as a record into a FIFO, which a slower consumer (UART bridge or bench monitor) drains through a valid/ready handshake. Overflow is flagged and counted rather than stalling the core; the core has no backpressure input.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `TS_WIDTH`, 16: timestamp width in bits.
- `FLAG_BITS`, 4: number of low bits of `FLAG_OUT` that are compared and recorded.
- `Clock` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low. 0 at a rising edge resets all state.
- `capture_en` input 1: when 0, no sampling, no compare, no push. The timestamp still runs.
- `RegisterOut_0` input 32: core register 0 value.
- `FLAG_OUT` input 32: core flags. Only bits `[FLAG_BITS-1:0]` are used.
- `trace_valid` output 1: FIFO head is valid.
- `trace_ready` input 1: the consumer accepts the head.
- `trace_data` output TS_WIDTH+FLAG_BITS+32: the FIFO head record, packed as {timestamp, flags, reg0}.
- `fifo_count` output clog2(DEPTH)+1: number of occupied entries.
- `overflow` output 1: sticky; set on any dropped record.
- `drop_count` output 8: number of dropped records, saturating at 255.
- `clear_overflow` input 1: clears `overflow` and `drop_count`.

## Operation
- Timestamp counter `ts`:
  - 0 in the first cycle after reset releases; +1 every cycle.
  - Wraps from 2^TS_WIDTH-1 to 0. It is independent of `capture_en`.
- `primed` flag: 0 after reset. It sets at the first edge where `capture_en`=1.
- Change event at an edge: `capture_en`=1 AND (`primed`=0 OR {FLAG_OUT[FLAG_BITS-1:0], RegisterOut_0} != stored `last`).
  - The first enabled sample after reset is always an event.
- `last` updates to the current inputs on every edge with `capture_en`=1, event or not.
  - Therefore a change that is dropped is not re-reported later.
- Pop: `trace_valid` AND `trace_ready` at an edge removes the head.
- Push on an event: write {ts, flags, reg0} at the tail, where `ts` is the counter value in the event cycle.
  - Accepted if `fifo_count` < DEPTH, or if `fifo_count` = DEPTH and a pop occurs in the same cycle.
  - Otherwise the record is dropped: `overflow` goes to 1, and `drop_count` increments unless it is already 255.
- Simultaneous push and pop: count is unchanged, and the tail and head pointers both advance.
- Pop when empty: impossible, since `trace_valid`=0; `trace_ready` is ignored.
- `clear_overflow`=1 at an edge: `overflow` goes to 0 and `drop_count` to 0.
  - If a drop occurs in the same cycle, the drop wins: `overflow` is 1 and `drop_count` is 1.
- Pointers are clog2(DEPTH) bits and wrap naturally. Full/empty are derived from `fifo_count`.
- The FIFO is show-ahead:
  - `trace_data` is the head entry whenever `trace_valid`=1.
  - It must hold stable while `trace_valid`=1 and `trace_ready`=0.
  - It is don't-care when `trace_valid`=0.
- Consumer rule: `trace_ready` may depend combinationally on `trace_valid`. No output depends combinationally on `trace_ready`.

## Timing
- Reset values: `trace_valid`=0, `fifo_count`=0, `overflow`=0, `drop_count`=0, `ts`=0, `primed`=0. `trace_data` holds the head entry, whose value is not reset.
- Latency: an event at edge N gives `trace_valid`=1 and the record visible on `trace_data` in the cycle after edge N.
- Throughput: one push and one pop per cycle.
- Reset during operation: the next cycle shows an empty FIFO, cleared flags and `ts`=0. Pending entries are discarded without being popped.
- The first enabled sample after reset is recorded even if it equals the pre-reset value.
- `capture_en` deasserted then reasserted: the compare is against the last enabled sample, not the values seen while disabled.

## Test plan
- **Reset and first capture.** Hold `reset`=0 for 2 edges. Release with `capture_en`=1, `RegisterOut_0`=0, `FLAG_OUT`=0, `trace_ready`=0. Expect `fifo_count`=1 after the first edge, and head = {ts=0, flags=0, reg0=0}.
- **Change detect and stamp.** Drive `RegisterOut_0`=0x0000_0005 for cycles 3–5, then 0xFFFF_FFFB with FLAG_OUT=0x9 at cycle 6. Expect exactly 3 records, with ts 0, 3 and 6. The last record has flags=0x9 and reg0=0xFFFFFFFB.
- **Overflow.** With `trace_ready`=0, cause 20 consecutive changes.
  - Expect `fifo_count`=16, `overflow`=1, `drop_count`=4. `trace_data` stays on the first record.
  - Then pulse `clear_overflow`: expect 0/0.
- **Full with simultaneous pop and push.** With the FIFO full, assert `trace_ready`=1 and one event in the same cycle. Expect `fifo_count` to stay 16, `drop_count` unchanged, and the new record at the tail.
- **Drain order and wrap.** Push 24 records while popping at random, with `trace_ready` at 50% duty.
  - Expect records to emerge in push order with no loss and no duplicates, while the pointers wrap.
  - `trace_data` must be stable under stall.
- **Reset mid-drain and timestamp wrap.** With 5 entries queued, pull `reset` low for 1 edge: expect `fifo_count`=0 and `trace_valid`=0 the next cycle. Then run 65 537 cycles with a change at ts 65 535 and one cycle later: expect stamps 0xFFFF then 0x0000.

Source files
------------

// File: rtl/reg_trace_buffer.sv
// Change-detecting trace capture for the core's register 0 and flags.
// Each change is timestamped and queued in a show-ahead FIFO drained by valid/ready.
module reg_trace_buffer #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned TS_WIDTH  = 16,
   parameter int unsigned FLAG_BITS = 4
) (
   input  logic                              Clock,
   input  logic                              reset,
   input  logic                              capture_en,
   input  logic [31:0]                       RegisterOut_0,
   input  logic [31:0]                       FLAG_OUT,
   output logic                              trace_valid,
   input  logic                              trace_ready,
   output logic [TS_WIDTH+FLAG_BITS+31:0]    trace_data,
   output logic [$clog2(DEPTH):0]            fifo_count,
   output logic                              overflow,
   output logic [7:0]                        drop_count,
   input  logic                              clear_overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = FLAG_BITS + 32;
   localparam int unsigned RW = TS_WIDTH + SW;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [TS_WIDTH-1:0] ts;
   logic [SW-1:0]       sample;
   logic [SW-1:0]       last;
   logic                primed;
   logic                event_hit;
   logic                pop;
   logic                push;
   logic                drop;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [RW-1:0]       mem [DEPTH];
   logic                unused_flags;

   assign unused_flags = ^FLAG_OUT[31:FLAG_BITS];

   always_comb begin
      sample    = {FLAG_OUT[FLAG_BITS-1:0], RegisterOut_0};
      event_hit = capture_en && (!primed || (sample != last));
      pop       = trace_valid && trace_ready;
      // A full FIFO still accepts a record when the head leaves in the same cycle.
      push      = event_hit && ((fifo_count != FULL) || pop);
      drop      = event_hit && !push;
   end

   assign trace_valid = (fifo_count != '0);
   assign trace_data  = mem[rd_ptr];

   always_ff @(posedge Clock) begin
      if (!reset) begin
         ts         <= '0;
         primed     <= 1'b0;
         last       <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         ts <= ts + TS_WIDTH'(1);
         if (capture_en) begin
            primed <= 1'b1;
            last   <= sample;
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
         // A drop in the same cycle as a clear restarts the count at one.
         if (drop) begin
            overflow <= 1'b1;
            if (clear_overflow)
               drop_count <= 8'd1;
            else if (drop_count != 8'hFF)
               drop_count <= drop_count + 8'd1;
         end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (reset && push) mem[wr_ptr] <= {ts, sample};
   end

endmodule

// File: tb/tb_reg_trace_buffer.sv
// Scoreboard bench for reg_trace_buffer: a queue-based reference model predicts
// records and status; a monitor compares whatever the DUT presents.
module tb_reg_trace_buffer;

   localparam int DEPTH = 16;
   localparam int RW    = 16 + 4 + 32;

   logic          Clock;
   logic          reset;
   logic          capture_en;
   logic [31:0]   RegisterOut_0;
   logic [31:0]   FLAG_OUT;
   logic          trace_valid;
   logic          trace_ready;
   logic [RW-1:0] trace_data;
   logic [4:0]    fifo_count;
   logic          overflow;
   logic [7:0]    drop_count;
   logic          clear_overflow;

   reg_trace_buffer #(.DEPTH(16), .TS_WIDTH(16), .FLAG_BITS(4)) dut (
      .Clock(Clock), .reset(reset), .capture_en(capture_en),
      .RegisterOut_0(RegisterOut_0), .FLAG_OUT(FLAG_OUT),
      .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
      .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count),
      .clear_overflow(clear_overflow)
   );

   int checks = 0;
   int errors = 0;

   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] got_q[$];

   int          m_cnt;
   int          m_ts;
   int          m_drop;
   bit          m_ovf;
   bit          m_primed;
   bit          m_init = 1'b0;
   logic [35:0] m_last;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: a change is any difference from the last enabled sample;
   // records are kept in push order, the model FIFO holds at most DEPTH.
   always @(posedge Clock) begin
      if (!reset) begin
         m_cnt = 0; m_ts = 0; m_drop = 0; m_ovf = 0; m_primed = 0; m_last = '0;
         exp_q.delete();
         m_init = 1'b1;
      end else begin
         bit pop_now, ev, dropped;
         logic [35:0] cur;
         cur     = {FLAG_OUT[3:0], RegisterOut_0};
         pop_now = (m_cnt > 0) && trace_ready;
         ev      = capture_en && (!m_primed || cur != m_last);
         dropped = 0;
         if (capture_en) begin
            m_primed = 1;
            m_last   = cur;
         end
         if (ev) begin
            if (m_cnt < DEPTH || pop_now) begin
               exp_q.push_back({16'(m_ts), cur});
               m_cnt++;
            end else dropped = 1;
         end
         if (pop_now) m_cnt--;
         if (dropped) begin
            m_ovf  = 1;
            m_drop = clear_overflow ? 1 : (m_drop < 255 ? m_drop + 1 : 255);
         end else if (clear_overflow) begin
            m_ovf  = 0;
            m_drop = 0;
         end
         m_ts = (m_ts + 1) % 65536;
      end
   end

   // Monitor: status against the model, head record against the scoreboard.
   always @(negedge Clock) begin
      if (m_init) begin
         chk("fifo_count", 64'(fifo_count), 64'(m_cnt));
         chk("trace_valid", 64'(trace_valid), 64'(m_cnt != 0));
         chk("overflow", 64'(overflow), 64'(m_ovf));
         chk("drop_count", 64'(drop_count), 64'(m_drop));
         if (trace_valid) begin
            if (exp_q.size() == 0) begin
               chk("head_unexpected", 64'(trace_valid), 64'd0);
            end else begin
               chk("trace_data", 64'(trace_data), 64'(exp_q[0]));
               if (trace_ready && reset) begin
                  got_q.push_back(trace_data);
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic drain();
      trace_ready = 1'b1;
      for (int i = 0; i < 100 && fifo_count != 0; i++) tick();
      trace_ready = 1'b0;
      chk("drain_empty", 64'(fifo_count), 64'd0);
   endtask

   task automatic bump();
      RegisterOut_0 = RegisterOut_0 + 32'(1 + $urandom_range(0, 255));
   endtask

   initial begin
      logic [31:0]   v0, vtail, saved;
      logic [15:0]   t0;
      logic [RW-1:0] rec;
      int            pushes, g;

      reset = 1'b0; capture_en = 1'b0; trace_ready = 1'b0; clear_overflow = 1'b0;
      RegisterOut_0 = '0; FLAG_OUT = '0;
      tick(); tick();

      // Reset release, first capture at ts 0
      reset = 1'b1; capture_en = 1'b1;
      tick();
      chk("first_count", 64'(fifo_count), 64'd1);
      chk("first_head", 64'(trace_data), 64'd0);

      // Change detection and stamping: changes at ts 3 and ts 6
      tick(); tick();
      RegisterOut_0 = 32'h0000_0005;
      tick(); tick(); tick();
      RegisterOut_0 = 32'hFFFF_FFFB; FLAG_OUT = 32'h9;
      tick();
      chk("stamp_count", 64'(fifo_count), 64'd3);
      drain();
      chk("stamp_popped", 64'(got_q.size()), 64'd3);
      if (got_q.size() == 3) begin
         chk("stamp_rec1", 64'(got_q[1]), 64'({16'd3, 4'h0, 32'h5}));
         chk("stamp_rec2", 64'(got_q[2]), 64'({16'd6, 4'h9, 32'hFFFF_FFFB}));
      end

      // Overflow: 20 changes with no consumer
      for (int i = 0; i < 20; i++) begin
         bump();
         if (i == 0) begin
            v0 = RegisterOut_0;
            t0 = 16'(m_ts);
         end
         tick();
      end
      chk("ovf_count", 64'(fifo_count), 64'd16);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_drops", 64'(drop_count), 64'd4);
      chk("ovf_head", 64'(trace_data), 64'({t0, 4'h9, v0}));

      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      chk("clear_flag", 64'(overflow), 64'd0);
      chk("clear_drops", 64'(drop_count), 64'd0);

      // Clear and drop in the same cycle: drop wins
      clear_overflow = 1'b1; bump();
      tick();
      chk("clrdrop_flag", 64'(overflow), 64'd1);
      chk("clrdrop_drops", 64'(drop_count), 64'd1);
      tick();
      clear_overflow = 1'b0;
      chk("clear2_drops", 64'(drop_count), 64'd0);

      // Full FIFO: simultaneous pop and push
      trace_ready = 1'b1; bump(); vtail = RegisterOut_0;
      tick();
      trace_ready = 1'b0;
      chk("fullpp_count", 64'(fifo_count), 64'd16);
      chk("fullpp_drops", 64'(drop_count), 64'd0);
      drain();
      rec = got_q[got_q.size() - 1];
      chk("fullpp_tail", 64'(rec[31:0]), 64'(vtail));

      // Random push/pop with pointer wrap
      pushes = 0;
      for (int c = 0; c < 400 && pushes < 24; c++) begin
         trace_ready = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0: begin bump(); pushes++; end
            1: begin FLAG_OUT[3:0] = FLAG_OUT[3:0] ^ 4'($urandom_range(1, 15)); pushes++; end
            2: FLAG_OUT[31:4] = 28'($urandom);
            default: ;
         endcase
         tick();
      end
      chk("rand_pushes", 64'(pushes), 64'd24);
      drain();

      // Disabled capture: compare resumes against last enabled sample
      saved = RegisterOut_0;
      capture_en = 1'b0; RegisterOut_0 = ~saved;
      tick(); tick();
      RegisterOut_0 = saved; capture_en = 1'b1;
      tick();
      chk("capen_noevent", 64'(fifo_count), 64'd0);
      RegisterOut_0 = saved ^ 32'h1;
      tick();
      chk("capen_event", 64'(fifo_count), 64'd1);

      // Reset with entries pending
      for (int i = 0; i < 4; i++) begin bump(); tick(); end
      chk("pre_reset_count", 64'(fifo_count), 64'd5);
      reset = 1'b0;
      tick();
      chk("reset_count", 64'(fifo_count), 64'd0);
      chk("reset_valid", 64'(trace_valid), 64'd0);
      reset = 1'b1;
      tick();
      chk("post_reset_first", 64'(fifo_count), 64'd1);
      chk("post_reset_ts", 64'(trace_data[51:36]), 64'd0);

      // Timestamp wrap
      trace_ready = 1'b1;
      g = 0;
      while (m_ts != 65535 && g < 70000) begin tick(); g++; end
      chk("wrap_reached", 64'(m_ts), 64'd65535);
      bump();
      tick();
      bump();
      tick(); tick(); tick();
      if (got_q.size() >= 2) begin
         rec = got_q[got_q.size() - 2];
         chk("wrap_ts_hi", 64'(rec[51:36]), 64'h0000_FFFF);
         rec = got_q[got_q.size() - 1];
         chk("wrap_ts_lo", 64'(rec[51:36]), 64'd0);
      end else begin
         chk("wrap_popped", 64'(got_q.size()), 64'd2);
      end
      chk("end_empty", 64'(fifo_count), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
